// File: rtl/program_loader.sv
// program_loader: boot loader from a byte-serial link into 64K-word memory.
// Optional checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        S_CNT_HI, S_CNT_LO, S_ADR_HI, S_ADR_LO,
        S_DAT_HI, S_DAT_LO, S_CSUM,
        S_FINISH, S_DONE, S_ERROR
    } state_t;
`else
    typedef enum logic [3:0] {
        S_CNT_HI, S_CNT_LO, S_ADR_HI, S_ADR_LO,
        S_DAT_HI, S_DAT_LO, S_DRAIN,
        S_FINISH, S_DONE
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [7:0]            hi_q, hi_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  we_q, we_d;
    logic                  ready_q, ready_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  acc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
    logic                  err_q, err_d;
`endif

    assign acc      = rx_valid && ready_q;
    assign rx_ready = ready_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign mem_we   = we_q;
    assign cpu_rst  = cpu_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

    // Frame parser: next state, write strobe, address/count bookkeeping.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = 1'b0;
        cpu_rst_d = cpu_rst_q;
        busy_d    = busy_q;
        done_d    = done_q;
`ifdef LOADER_CHECKSUM_EN
        err_d     = err_q;
        csum_d    = csum_q;
        if (acc && state_q != S_CSUM) begin
            csum_d = csum_q ^ rx_data;
        end
`endif
        // Address advances on the edge that closes the write cycle.
        if (we_q) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end
        if (acc) begin
            busy_d = 1'b1;
        end
        unique case (state_q)
            S_CNT_HI: begin
                if (acc) begin
                    hi_d    = rx_data;
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (acc) begin
                    cnt_d   = {hi_q, rx_data};
                    state_d = S_ADR_HI;
                end
            end
            S_ADR_HI: begin
                if (acc) begin
                    hi_d    = rx_data;
                    state_d = S_ADR_LO;
                end
            end
            S_ADR_LO: begin
                if (acc) begin
                    addr_d = ADDR_WIDTH'({hi_q, rx_data});
                    if (cnt_q == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_FINISH;
`endif
                    end else begin
                        state_d = S_DAT_HI;
                    end
                end
            end
            S_DAT_HI: begin
                if (acc) begin
                    hi_d    = rx_data;
                    state_d = S_DAT_LO;
                end
            end
            S_DAT_LO: begin
                if (acc) begin
                    data_d = DATA_WIDTH'({hi_q, rx_data});
                    we_d   = 1'b1;
                    cnt_d  = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DRAIN;
`endif
                    end else begin
                        state_d = S_DAT_HI;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (acc) begin
                    if (rx_data == csum_q) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
`else
            // Lets the final write cycle complete before FINISH.
            S_DRAIN: begin
                state_d = S_FINISH;
            end
`endif
            S_FINISH: begin
                state_d   = S_DONE;
                done_d    = 1'b1;
                cpu_rst_d = 1'b0;
                busy_d    = 1'b0;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_CNT_HI;
            end
        endcase
`ifdef LOADER_CHECKSUM_EN
        ready_d = state_d inside {S_CNT_HI, S_CNT_LO, S_ADR_HI,
                                 S_ADR_LO, S_DAT_HI, S_DAT_LO, S_CSUM};
`else
        ready_d = state_d inside {S_CNT_HI, S_CNT_LO, S_ADR_HI,
                                 S_ADR_LO, S_DAT_HI, S_DAT_LO};
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CNT_HI;
            hi_q      <= 8'h00;
            cnt_q     <= 16'h0000;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            ready_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= 8'h00;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            ready_q   <= ready_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
            err_q     <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed table, corner sequences, random frames.
// Checksum expectations follow LOADER_CHECKSUM_EN.
module tb_program_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    program_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bus monitor
    int          cyc = 0;
    logic [15:0] wa[$];
    logic [15:0] wd[$];
    int          wc[$];
    int          acq[$];
    int          acc_n = 0;
    int          last_acc = -1;
    int          done_at = -1;
    int          err_at = -1;
    int          dbl_we = 0;
    logic        prev_we = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            wa.delete(); wd.delete(); wc.delete(); acq.delete();
            acc_n = 0; last_acc = -1; done_at = -1; err_at = -1;
            dbl_we = 0; prev_we = 1'b0;
        end else begin
            if (mem_we) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_data);
                wc.push_back(cyc);
                if (prev_we) dbl_we++;
            end
            prev_we = mem_we;
            if (rx_valid && rx_ready) begin
                acc_n++;
                last_acc = cyc;
                acq.push_back(cyc);
            end
            if (done && done_at < 0) done_at = cyc;
            if (err && err_at < 0) err_at = cyc;
        end
    end

    task automatic do_reset(input bit chk);
        @(posedge clk); #1;
        rst = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        if (chk) begin
            check("reset flags {rdy,we,cpu_rst,busy,done,err}",
                  {26'd0, rx_ready, mem_we, cpu_rst, busy, done, err},
                  32'b001000);
            check("reset mem_addr", mem_addr, 0);
            check("reset mem_data", mem_data, 0);
        end
    endtask

    task automatic put(input logic [7:0] b, input bit gap);
        bit got;
        got = 1'b0;
        if (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'hA5;
            @(posedge clk); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("handshake timeout", 0, 1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Reference frame encoder: header, words, XOR checksum (optionally corrupted)
    task automatic build(input int n, input logic [15:0] a,
                         input logic [15:0] w[$], input bit corrupt,
                         output logic [7:0] f[$]);
        logic [7:0] x;
        f.delete();
        f.push_back(8'(n >> 8));
        f.push_back(8'(n));
        f.push_back(a[15:8]);
        f.push_back(a[7:0]);
        for (int i = 0; i < n; i++) begin
            f.push_back(w[i][15:8]);
            f.push_back(w[i][7:0]);
        end
        x = 8'h00;
        foreach (f[i]) x ^= f[i];
        if (CS) f.push_back(corrupt ? (x ^ 8'h01) : x);
    endtask

    task automatic run_frame(input string lbl, input logic [7:0] f[$],
                             input bit gap, input logic [15:0] ea[$],
                             input logic [15:0] ed[$], input bit exp_err);
        bit fin;
        int a0;
        int w0;
        foreach (f[i]) put(f[i], gap);
        fin = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || err) begin
                fin = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        check({lbl, " finished"}, {31'd0, fin}, 1);
        check({lbl, " write count"}, wa.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            check($sformatf("%s wr%0d addr", lbl, i), wa[i], ea[i]);
            check($sformatf("%s wr%0d data", lbl, i), wd[i], ed[i]);
            if (acq.size() > 5 + 2 * i)
                check($sformatf("%s wr%0d cycle", lbl, i),
                      wc[i], acq[5 + 2 * i] + 1);
        end
        check({lbl, " bytes taken"}, acc_n, f.size());
        check({lbl, " we width"}, dbl_we, 0);
        check({lbl, " done"}, {31'd0, done}, {31'd0, !exp_err});
        check({lbl, " err"}, {31'd0, err}, {31'd0, exp_err});
        check({lbl, " cpu_rst"}, {31'd0, cpu_rst}, {31'd0, exp_err});
        check({lbl, " busy"}, {31'd0, busy}, 0);
        check({lbl, " rx_ready"}, {31'd0, rx_ready}, 0);
        if (!exp_err) begin
            check({lbl, " done latency"}, done_at - last_acc,
                  (CS || ea.size() == 0) ? 2 : 3);
        end else begin
            check({lbl, " err latency"}, err_at - last_acc, 1);
            a0 = acc_n;
            w0 = wa.size();
            rx_data  = 8'h77;
            rx_valid = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            rx_valid = 1'b0;
            check({lbl, " ignored bytes"}, acc_n, a0);
            check({lbl, " no late writes"}, wa.size(), w0);
            check({lbl, " err sticky"}, {31'd0, err, rx_ready}, 2);
        end
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [15:0] addr;
        logic [15:0] w0;
        logic [15:0] w1;
        bit          corrupt;
        bit          gap;
        int          exp_nwr;
        logic [15:0] exp_a0;
        logic [15:0] exp_d0;
        logic [15:0] exp_a1;
        logic [15:0] exp_d1;
        bit          exp_err;
    } vec_t;

    initial begin
        vec_t        tbl[5];
        logic [7:0]  f[$];
        logic [15:0] w[$];
        logic [15:0] ea[$];
        logic [15:0] ed[$];

        tbl[0] = '{"basic", 2, 16'h0010, 16'h1234, 16'hABCD, 0, 0,
                   2, 16'h0010, 16'h1234, 16'h0011, 16'hABCD, 0};
        tbl[1] = '{"badcsum", 2, 16'h0010, 16'h1234, 16'hABCD, 1, 0,
                   2, 16'h0010, 16'h1234, 16'h0011, 16'hABCD, CS};
        tbl[2] = '{"wrap", 2, 16'hFFFF, 16'h0001, 16'h0002, 0, 0,
                   2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0002, 0};
        tbl[3] = '{"empty", 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,
                   0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};
        tbl[4] = '{"beef", 1, 16'h0020, 16'hBEEF, 16'h0000, 0, 0,
                   1, 16'h0020, 16'hBEEF, 16'h0000, 16'h0000, 0};

        do_reset(1'b1);
        for (int t = 0; t < 5; t++) begin
            w = '{tbl[t].w0, tbl[t].w1};
            build(tbl[t].n, tbl[t].addr, w, tbl[t].corrupt, f);
            ea.delete(); ed.delete();
            if (tbl[t].exp_nwr > 0) begin
                ea.push_back(tbl[t].exp_a0); ed.push_back(tbl[t].exp_d0);
            end
            if (tbl[t].exp_nwr > 1) begin
                ea.push_back(tbl[t].exp_a1); ed.push_back(tbl[t].exp_d1);
            end
            run_frame(tbl[t].name, f, tbl[t].gap, ea, ed, tbl[t].exp_err);
            do_reset(1'b0);
        end

        // Abort a frame after its first word, then load a full frame
        put(8'h00, 0); put(8'h02, 0); put(8'h00, 0);
        put(8'h10, 0); put(8'h12, 0); put(8'h34, 0);
        @(negedge clk); #1;
        check("partial write count", wa.size(), 1);
        check("partial busy/cpu_rst", {30'd0, busy, cpu_rst}, 3);
        do_reset(1'b1);
        w = '{16'h1234, 16'hABCD};
        build(2, 16'h0010, w, 1'b0, f);
        ea = '{16'h0010, 16'h0011};
        ed = '{16'h1234, 16'hABCD};
        run_frame("after abort", f, 1'b0, ea, ed, 1'b0);

        // Random frames against the reference model
        for (int k = 0; k < 25; k++) begin
            int          n;
            logic [15:0] a;
            bit          bad;
            bit          gp;
            do_reset(1'b0);
            n = $urandom_range(0, 5);
            if ($urandom_range(0, 2) == 0)
                a = 16'hFFFF - 16'($urandom_range(0, 3));
            else
                a = 16'($urandom);
            bad = CS && ($urandom_range(0, 3) == 0);
            gp  = 1'($urandom_range(0, 1));
            w.delete(); ea.delete(); ed.delete();
            for (int i = 0; i < n; i++) begin
                w.push_back(16'($urandom));
                ea.push_back(a + 16'(i));
                ed.push_back(w[i]);
            end
            build(n, a, w, bad, f);
            run_frame($sformatf("rand%0d", k), f, gp, ea, ed, bad);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader between a byte-serial host link and the processor's unified 64K-word memory. It receives a framed image, writes it word by word through a single memory write port, and holds the processor in reset until the image is fully and correctly committed. It drives the same address/data/write-enable triple that the processor drives at run time; a top-level mux selects the loader while `cpu_rst` is high.

## Interface

Parameters:
- `ADDR_WIDTH`, 16, memory address width (64K-word memory).
- `DATA_WIDTH`, 16, memory word width; fixed at 2 bytes per word.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte; a transfer occurs on a rising edge of `clk` with `rx_valid && rx_ready`.
- `mem_addr`  out  ADDR_WIDTH  write address.
- `mem_data`  out  DATA_WIDTH  write data.
- `mem_we`  out  1  write strobe; memory writes on the rising edge where it is high.
- `cpu_rst`  out  1  processor reset; high until load succeeds.
- `busy`  out  1  frame in progress.
- `done`  out  1  load complete, sticky until `rst`.
- `err`  out  1  checksum failure, sticky until `rst`.

## Operation

- Frame: CNT_HI, CNT_LO (word count N, big-endian), ADR_HI, ADR_LO (start address A), then N words as HI/LO byte pairs, then CSUM (only with the checksum feature).
- State sequence: CNT_HI → CNT_LO → ADR_HI → ADR_LO → DAT_HI ↔ DAT_LO (N times) → [CSUM] → FINISH → DONE; CSUM mismatch → ERROR.
- N = 0 is legal. ADR_LO goes straight to CSUM (feature on) or FINISH (feature off). No memory write occurs.
- Each accepted DAT_LO assembles {HI, LO} into `mem_data` and produces one `mem_we` pulse at `mem_addr`. After the pulse, `mem_addr` increments modulo 2^ADDR_WIDTH, so 0xFFFF wraps to 0x0000. The remaining count decrements.
- `rx_ready` is 1 in CNT_HI through CSUM and 0 in FINISH, DONE and ERROR. Bytes offered in those states are ignored.
- Checksum: the running XOR of every accepted byte from CNT_HI through the last DAT_LO. The CSUM byte must equal it.
- `busy` goes to 1 on the first accepted byte and returns to 0 on entering DONE or ERROR.
- DONE: `done` = 1 and `cpu_rst` = 0.
- ERROR: `err` = 1, `cpu_rst` stays 1, `rx_ready` = 0. Only `rst` leaves ERROR or DONE.

## Timing

- Reset values: `rx_ready` = 0, `mem_addr` = 0, `mem_data` = 0, `mem_we` = 0, `cpu_rst` = 1, `busy` = 0, `done` = 0, `err` = 0. State is CNT_HI.
- `rx_ready` rises in the first cycle after `rst` deasserts.
- `rst` asserted mid-frame aborts the frame. Partial writes already made remain in memory, and the loader restarts at CNT_HI.
- One byte can be accepted per cycle, so there is at most one write every two cycles.
- `mem_we` is high for exactly the one cycle after the edge that accepted DAT_LO. `mem_addr` and `mem_data` are stable during that cycle, and `mem_addr` changes on the following edge.
- FINISH lasts one cycle and guarantees the last write has been committed.
- `cpu_rst` falls, and `done` rises, on the edge leaving FINISH:
  - feature on: 2 cycles after the CSUM byte is accepted;
  - feature off: 3 cycles after the last DAT_LO is accepted (1 cycle after the `mem_we` pulse).
- On a checksum mismatch, `err` rises one cycle after CSUM is accepted.

## Configuration

- `LOADER_CHECKSUM_EN` defined: the CSUM byte is expected and verified, and ERROR is reachable.
- Not defined: there is no CSUM state and no XOR register. The frame ends after the last DAT_LO (or after ADR_LO when N = 0), `err` is tied to 0, and ERROR is unreachable.

## Test plan

- Basic load (feature on). Bytes 00 02 00 10 12 34 AB CD 52, one per cycle.
  - Required: `mem_we` pulses with (0x0010, 0x1234) and (0x0011, 0xABCD).
  - Required: `done` = 1 and `cpu_rst` = 0 two cycles after 0x52 is accepted, with `err` = 0.
- Bad checksum. Same frame with final byte 0x53.
  - Required: `err` = 1 and `cpu_rst` stays 1.
  - Required: `rx_ready` = 0, and further bytes are ignored.
- Wrap-around. Bytes 00 02 FF FF 00 01 00 02 01.
  - Required: writes (0xFFFF, 0x0001) then (0x0000, 0x0002), then `done`.
- Empty image and back-pressure. Bytes 00 00 00 00 00, with `rx_valid` toggling every other cycle.
  - Required: no `mem_we` pulse, and `done` = 1.
  - Required: each byte is consumed only when `rx_valid && rx_ready`.
- Mid-frame reset. Send 00 02 00 10 12 34, pulse `rst` for one cycle, then send the basic-load frame.
  - Required: all outputs return to their reset values.
  - Required: the second frame loads correctly.
- Feature off. Bytes 00 01 00 20 BE EF.
  - Required: write (0x0020, 0xBEEF), and `cpu_rst` falls 3 cycles after 0xEF is accepted.
